lsu_mem_master: RTL and testbench

- Load/store initiator for the multicycle MIPS32 core; drives the word-only, aligned-address memory port (combinational read, posedge write) on behalf of the datapath.
- Converts byte, halfword and word loads and stores into aligned word transactions. Sub-word stores use read-modify-write.
- Performs little-endian lane selection and sign/zero extension, flags misalignment, and hands results back over a valid/ready response handshake.

---
 rtl/lsu_mem_master_pkg.sv | 25 ++
 rtl/lsu_mem_master_if.sv | 35 +++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/lsu_mem_master.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_master_pkg.sv
// Shared types and constants for the LSU memory master: op field layout,
// size codes, FSM state encoding and the word-alignment helper.
package lsu_mem_master_pkg;

   localparam int LSU_W         = 32;
   localparam int LSU_OP_W      = 4;
   localparam int LSU_STORE_BIT = 3;
   localparam int LSU_UNS_BIT   = 2;

   localparam logic [1:0] LSU_SZ_B = 2'b00;
   localparam logic [1:0] LSU_SZ_H = 2'b01;
   localparam logic [1:0] LSU_SZ_W = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_RD   = 2'b01,
      LSU_WR   = 2'b10,
      LSU_RESP = 2'b11
   } lsu_state_e;

   function automatic logic [LSU_W-1:0] lsu_word_addr(input logic [LSU_W-1:0] a);
      return {a[LSU_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// CPU request/response handshake plus word-wide memory port of the LSU.
// The master modport is the LSU side; slave is the CPU/memory environment.
interface lsu_mem_master_if
   import lsu_mem_master_pkg::*;
#(
   parameter int W = LSU_W
);
   logic                req_valid;
   logic                req_ready;
   logic [LSU_OP_W-1:0] req_op;
   logic [W-1:0]        req_addr;
   logic [W-1:0]        req_wdata;
   logic                resp_valid;
   logic                resp_ready;
   logic [W-1:0]        resp_rdata;
   logic                resp_err;
   logic                read_en;
   logic [W-1:0]        read_addr;
   logic [W-1:0]        read_data;
   logic                write_en;
   logic [W-1:0]        write_addr;
   logic [W-1:0]        write_data;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready, read_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             read_en, read_addr, write_en, write_addr, write_data
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, resp_ready, read_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             read_en, read_addr, write_en, write_addr, write_data
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane datapath: load extract/extend, sub-word store
// merge and the misalignment / reserved-size check.
module lsu_lane_align
   import lsu_mem_master_pkg::*;
(
   input  logic [LSU_W-1:0] word_i,
   input  logic [LSU_W-1:0] wdata_i,
   input  logic [1:0]       offset_i,
   input  logic [1:0]       size_i,
   input  logic             uns_i,
   output logic [LSU_W-1:0] load_o,
   output logic [LSU_W-1:0] merge_o,
   output logic             misalign_o
);
   logic [4:0]  bsh_s;
   logic [4:0]  hsh_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select by offset, then extend or merge according to size.
   always_comb begin
      bsh_s      = {offset_i, 3'b000};
      hsh_s      = {offset_i[1], 4'b0000};
      byte_s     = word_i[bsh_s +: 8];
      half_s     = word_i[hsh_s +: 16];
      load_o     = word_i;
      merge_o    = word_i;
      misalign_o = 1'b0;
      case (size_i)
         LSU_SZ_B: begin
            load_o              = {{(LSU_W-8){byte_s[7] & ~uns_i}}, byte_s};
            merge_o[bsh_s +: 8] = wdata_i[7:0];
         end
         LSU_SZ_H: begin
            load_o               = {{(LSU_W-16){half_s[15] & ~uns_i}}, half_s};
            merge_o[hsh_s +: 16] = wdata_i[15:0];
            misalign_o           = offset_i[0];
         end
         LSU_SZ_W: begin
            load_o     = word_i;
            merge_o    = wdata_i;
            misalign_o = |offset_i;
         end
         default: begin
            load_o     = {LSU_W{1'b0}};
            merge_o    = word_i;
            misalign_o = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns byte/half/word CPU requests into aligned word
// reads and writes (read-modify-write for sub-word stores).
module lsu_mem_master
   import lsu_mem_master_pkg::*;
#(
   parameter int W = LSU_W
)(
   input  logic clk,
   input  logic rst,
   lsu_mem_master_if.master bus
);
   lsu_state_e          state_q, state_d;
   logic [LSU_OP_W-1:0] op_q, op_d;
   logic [W-1:0]        addr_q, addr_d;
   logic [W-1:0]        wdata_q, wdata_d;
   logic [W-1:0]        resp_rdata_q, resp_rdata_d;
   logic [W-1:0]        write_data_q, write_data_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic                req_ready_q, req_ready_d;

   logic                idle_s;
   logic [1:0]          lane_off_s;
   logic [1:0]          lane_size_s;
   logic [W-1:0]        load_s;
   logic [W-1:0]        merge_s;
   logic                misalign_s;

   // In IDLE the lane unit checks the incoming request; afterwards it works on the latched one.
   assign idle_s      = (state_q == LSU_IDLE);
   assign lane_off_s  = idle_s ? bus.req_addr[1:0] : addr_q[1:0];
   assign lane_size_s = idle_s ? bus.req_op[1:0]   : op_q[1:0];

   lsu_lane_align u_lane (
      .word_i     (bus.read_data),
      .wdata_i    (wdata_q),
      .offset_i   (lane_off_s),
      .size_i     (lane_size_s),
      .uns_i      (op_q[LSU_UNS_BIT]),
      .load_o     (load_s),
      .merge_o    (merge_s),
      .misalign_o (misalign_s)
   );

   // Next-state and output-register computation for the four-state transaction FSM.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      write_data_d = write_data_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      req_ready_d  = req_ready_q;
      case (state_q)
         LSU_IDLE: begin
            if (bus.req_valid) begin
               op_d         = bus.req_op;
               addr_d       = bus.req_addr;
               wdata_d      = bus.req_wdata;
               resp_rdata_d = {W{1'b0}};
               resp_err_d   = 1'b0;
               req_ready_d  = 1'b0;
               if (misalign_s) begin
                  state_d      = LSU_RESP;
                  resp_err_d   = 1'b1;
                  resp_valid_d = 1'b1;
               end else if (bus.req_op[LSU_STORE_BIT] && (bus.req_op[1:0] == LSU_SZ_W)) begin
                  state_d      = LSU_WR;
                  write_data_d = bus.req_wdata;
               end else begin
                  state_d = LSU_RD;
               end
            end else begin
               state_d = LSU_IDLE;
            end
         end
         LSU_RD: begin
            if (op_q[LSU_STORE_BIT]) begin
               state_d      = LSU_WR;
               write_data_d = merge_s;
            end else begin
               state_d      = LSU_RESP;
               resp_rdata_d = load_s;
               resp_valid_d = 1'b1;
            end
         end
         LSU_WR: begin
            state_d      = LSU_RESP;
            resp_valid_d = 1'b1;
         end
         LSU_RESP: begin
            if (bus.resp_ready) begin
               state_d      = LSU_IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end else begin
               state_d = LSU_RESP;
            end
         end
         default: begin
            state_d      = LSU_IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset drops everything back to an idle, quiet port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= LSU_IDLE;
         op_q         <= {LSU_OP_W{1'b0}};
         addr_q       <= {W{1'b0}};
         wdata_q      <= {W{1'b0}};
         resp_rdata_q <= {W{1'b0}};
         write_data_q <= {W{1'b0}};
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         req_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         write_data_q <= write_data_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         req_ready_q  <= req_ready_d;
      end
   end

   // Strobes decode straight from state so an asserted reset kills them at once.
   assign bus.read_en    = (state_q == LSU_RD);
   assign bus.write_en   = (state_q == LSU_WR);
   assign bus.read_addr  = lsu_word_addr(addr_q);
   assign bus.write_addr = lsu_word_addr(addr_q);
   assign bus.write_data = write_data_q;
   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed cases plus random traffic
// checked against a byte-level reference memory model.
module tb_lsu_mem_master;
   logic clk;
   logic rst;

   lsu_mem_master_if #(.W(32)) bus ();

   lsu_mem_master #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic [31:0] addr;
      logic [31:0] wword;
      int          exp_rd;
      int          exp_wr;
      int          acc;
      int          rd_base;
      int          wr_base;
   } ent_t;

   ent_t        sbq[$];
   logic [31:0] mem     [0:15];
   logic [31:0] ref_mem [0:15];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          hold_cnt = 0;
   bit          rand_rr = 0;
   bit          seen_first = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Memory behind the port: combinational read, posedge write.
   assign bus.read_data = mem[bus.read_addr[5:2]];
   always @(posedge clk) if (bus.write_en) mem[bus.write_addr[5:2]] <= bus.write_data;

   // resp_ready changes 2 time units after posedge so it is stable around the sampling points.
   always @(posedge clk) begin
      #2;
      if (hold_cnt > 0) begin
         bus.resp_ready = 1'b0;
         hold_cnt = hold_cnt - 1;
      end else if (rand_rr) begin
         bus.resp_ready = 1'($urandom_range(0, 1));
      end else begin
         bus.resp_ready = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: what a byte-addressed little-endian memory would return/store.
   task automatic model(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, output ent_t e);
      int          nbytes;
      int          sh;
      logic [31:0] mask;
      logic [31:0] word;
      logic [31:0] val;
      nbytes = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
      sh     = 8 * int'(addr % 4);
      mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      word   = ref_mem[addr / 4];
      e.addr = addr & ~32'd3;
      e.rdata = 32'd0;
      e.err = 1'b0;
      e.wword = 32'd0;
      e.exp_rd = 0;
      e.exp_wr = 0;
      if (op[1:0] == 2'd3 || (addr % nbytes) != 0) begin
         e.err = 1'b1;
         e.lat = 1;
      end else if (!op[3]) begin
         val = (word >> sh) & mask;
         if (!op[2] && nbytes < 4 && val >= (32'd1 << (8 * nbytes - 1)))
            val = val | ~mask;
         e.rdata = val;
         e.lat = 2;
         e.exp_rd = 1;
      end else begin
         e.wword = (word & ~(mask << sh)) | ((wd & mask) << sh);
         ref_mem[addr / 4] = e.wword;
         e.lat = (nbytes == 4) ? 2 : 3;
         e.exp_rd = (nbytes == 4) ? 0 : 1;
         e.exp_wr = 1;
      end
   endtask

   task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input bit keep, input int hold);
      ent_t e;
      int   n;
      @(negedge clk);
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n = n + 1;
      end
      if (n >= 100) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL accept_timeout: req_ready=%b expected 1 within 100 cycles", bus.req_ready);
         bus.req_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         model(op, addr, wd, e);
         e.acc     = cyc;
         e.rd_base = rd_cnt;
         e.wr_base = wr_cnt;
         sbq.push_back(e);
         if (hold > 0) hold_cnt = hold;
         if (!keep) bus.req_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || bus.req_ready !== 1'b1) && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      if (n >= 200) begin
         total = total + 1;
         bad = bad + 1;
         $display("FAIL drain_timeout: pending=%0d expected 0", sbq.size());
      end
   endtask

   // Monitor: checks memory-port activity and pops the scoreboard on each response handshake.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.read_en)  rd_cnt = rd_cnt + 1;
         if (bus.write_en) wr_cnt = wr_cnt + 1;
         if (sbq.size() != 0) begin
            if (bus.read_en) chk("read_addr", bus.read_addr, sbq[0].addr);
            if (bus.write_en) begin
               chk("write_addr", bus.write_addr, sbq[0].addr);
               chk("write_data", bus.write_data, sbq[0].wword);
            end
         end
         if (bus.resp_valid) begin
            if (sbq.size() == 0) begin
               total = total + 1;
               bad = bad + 1;
               $display("FAIL unexpected_resp: resp_valid=1 expected no response");
            end else begin
               if (!seen_first) begin
                  chk("latency", 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                  seen_first = 1;
               end
               chk("resp_rdata", bus.resp_rdata, sbq[0].rdata);
               chk("resp_err", {31'd0, bus.resp_err}, {31'd0, sbq[0].err});
               chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
               if (bus.resp_ready) begin
                  chk("read_strobes", 32'(rd_cnt - sbq[0].rd_base), 32'(sbq[0].exp_rd));
                  chk("write_strobes", 32'(wr_cnt - sbq[0].wr_base), 32'(sbq[0].exp_wr));
                  void'(sbq.pop_front());
                  seen_first = 0;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] old;
      rst = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op = 4'd0;
      bus.req_addr = 32'd0;
      bus.req_wdata = 32'd0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[2] = 32'hDEAD_BEEF;  ref_mem[2] = 32'hDEAD_BEEF;
      mem[3] = 32'h1122_3344;  ref_mem[3] = 32'h1122_3344;
      #12;
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst_read_en", {31'd0, bus.read_en}, 32'd0);
      chk("rst_write_en", {31'd0, bus.write_en}, 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_write_data", bus.write_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Directed cases from the block's intended use.
      do_req(4'b0010, 32'h0000_0008, 32'd0, 0, 0);
      wait_drain();
      mem[2] = 32'h80FF_7F01;  ref_mem[2] = 32'h80FF_7F01;
      do_req(4'b0000, 32'h0000_000B, 32'd0, 0, 0);
      do_req(4'b0100, 32'h0000_000B, 32'd0, 0, 0);
      do_req(4'b0001, 32'h0000_000A, 32'd0, 0, 0);
      do_req(4'b1000, 32'h0000_000D, 32'h1234_56AB, 0, 0);
      do_req(4'b0010, 32'h0000_000C, 32'd0, 0, 0);
      do_req(4'b0010, 32'h0000_0006, 32'd0, 0, 0);
      do_req(4'b0011, 32'h0000_0000, 32'd0, 0, 0);
      // Back-pressure with req_valid held: the repeat is accepted only once IDLE returns.
      do_req(4'b0001, 32'h0000_0012, 32'd0, 1, 5);
      do_req(4'b0001, 32'h0000_0012, 32'd0, 0, 0);
      wait_drain();

      // Reset asserted while a word store sits in WR.
      old = ref_mem[4];
      @(negedge clk);
      bus.req_op = 4'b1010;
      bus.req_addr = 32'h0000_0010;
      bus.req_wdata = 32'hCAFE_F00D;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("wr_state_write_en", {31'd0, bus.write_en}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_write_en", {31'd0, bus.write_en}, 32'd0);
      chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_mid_write_addr", bus.write_addr, 32'd0);
      chk("rst_mid_write_data", bus.write_data, 32'd0);
      chk("rst_mid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_mid_mem_kept", mem[4], old);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

      // Random traffic with random response back-pressure.
      rand_rr = 1;
      for (int k = 0; k < 200; k++) begin
         op   = 4'($urandom_range(0, 15));
         addr = 32'($urandom_range(0, 63));
         wd   = $urandom;
         do_req(op, addr, wd, 0, 0);
      end
      wait_drain();
      rand_rr = 0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
